// File: rtl/taumin_uart_packetizer.sv
// -----------------------------------------------------------------------------
// taumin_uart_packetizer
// Buffers taumin results from the YIN pitch detector in a small FIFO and sends
// each one to uart_transmit as a 5-byte packet:
//   [SYNC_BYTE, SEQ, TAU_HI, TAU_LO, CHK]   CHK = SEQ ^ TAU_HI ^ TAU_LO
// TAU is taumin zero-extended to 16 bits and sent big-endian. SEQ counts
// packets sent and wraps at 255. If a sample arrives while the FIFO is full,
// it is dropped and counted. The detector is never stalled.
//
// Ports
//   clk_in          system clock (100 MHz)
//   rst_in          asynchronous active-low reset
//   taumin_in       period estimate from yin
//   valid_in        1-cycle strobe qualifying taumin_in
//   tx_busy_in      uart_transmit busy_out
//   tx_byte_out     byte to uart_transmit data_byte_in (registered)
//   tx_trigger_out  1-cycle send strobe to uart_transmit trigger_in
//   drop_count_out  samples dropped on a full FIFO, saturating at 255
//   busy_out        FIFO non-empty or packet in flight
// -----------------------------------------------------------------------------
module taumin_uart_packetizer #(
    parameter int unsigned TAU_WIDTH  = 11,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [TAU_WIDTH-1:0] taumin_in,
    input  logic                 valid_in,
    input  logic                 tx_busy_in,
    output logic [7:0]           tx_byte_out,
    output logic                 tx_trigger_out,
    output logic [7:0]           drop_count_out,
    output logic                 busy_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE_C  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO_C = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Packet checksum: XOR of the three payload bytes
    function automatic logic [7:0] pkt_checksum(input logic [7:0] seq, input logic [15:0] tau);
        return seq ^ tau[15:8] ^ tau[7:0];
    endfunction

    // Byte at position idx of the packet for (seq, tau)
    function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [7:0] seq,
                                            input logic [15:0] tau);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = seq;
            3'd2:    b = tau[15:8];
            3'd3:    b = tau[7:0];
            3'd4:    b = pkt_checksum(seq, tau);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [TAU_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [15:0]          tau_r;
    logic [2:0]           byte_idx_r;
    logic [7:0]           seq_r;
    logic [7:0]           tx_byte_r;
    logic [7:0]           drop_r;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 trigger_s;
    logic                 last_byte_s;
    logic [15:0]          head_ext_s;

    assign fifo_empty_s = (count_r == CNT_ZERO_C);
    assign fifo_full_s  = (count_r == CNT_FULL_C);
    assign last_byte_s  = (byte_idx_r == 3'd4);
    assign head_ext_s   = 16'(fifo_mem_r[rd_ptr_r]);

    // Next state, FIFO pop and send strobe
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        trigger_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The trigger is gated by busy in the same cycle, so the UART can
                // never see a strobe while it is transmitting.
                if (!tx_busy_in) begin
                    trigger_s   = 1'b1;
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_GAP: begin
                // One dead cycle lets the UART raise busy before the next check.
                if (last_byte_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Push/drop decision; a full FIFO still accepts when a pop frees a slot this cycle
    always_comb begin
        push_s = 1'b0;
        drop_s = 1'b0;
        if (valid_in) begin
            if (!fifo_full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by count_r)
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= taumin_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet datapath: sample register, byte index, sequence number, output byte
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tau_r      <= 16'h0000;
            byte_idx_r <= 3'd0;
            seq_r      <= 8'h00;
            tx_byte_r  <= 8'h00;
        end else if (pop_s) begin
            // The sync byte is ready on the output before the first SEND cycle.
            tau_r      <= head_ext_s;
            byte_idx_r <= 3'd0;
            tx_byte_r  <= SYNC_BYTE;
        end else if (state_r == ST_GAP) begin
            if (last_byte_s) begin
                seq_r <= seq_r + 8'd1;
            end else begin
                byte_idx_r <= byte_idx_r + 3'd1;
                tx_byte_r  <= pkt_byte(byte_idx_r + 3'd1, seq_r, tau_r);
            end
        end
    end

    // Saturating overload counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_r <= 8'h00;
        end else if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    assign tx_byte_out    = tx_byte_r;
    assign tx_trigger_out = trigger_s;
    assign drop_count_out = drop_r;
    assign busy_out       = (state_r != ST_IDLE) | !fifo_empty_s;

endmodule

// File: tb/tb_taumin_uart_packetizer.sv
// -----------------------------------------------------------------------------
// Testbench for taumin_uart_packetizer.
// Accepted samples are turned into the 5 expected packet bytes and pushed into
// a scoreboard queue. A monitor compares each byte the DUT triggers against the
// queue, and it also checks trigger spacing and the busy handshake. A UART
// responder raises busy for a programmable number of cycles after each trigger.
// It can also hold busy high permanently.
// -----------------------------------------------------------------------------
module tb_taumin_uart_packetizer;

    localparam int TW    = 11;
    localparam int DEPTH = 8;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [TW-1:0] taumin_in;
    logic          valid_in;
    logic          tx_busy_in;
    logic [7:0]    tx_byte_out;
    logic          tx_trigger_out;
    logic [7:0]    drop_count_out;
    logic          busy_out;

    taumin_uart_packetizer #(.TAU_WIDTH(TW), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .taumin_in      (taumin_in),
        .valid_in       (valid_in),
        .tx_busy_in     (tx_busy_in),
        .tx_byte_out    (tx_byte_out),
        .tx_trigger_out (tx_trigger_out),
        .drop_count_out (drop_count_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] seq_model = 8'h00;
    int         drop_model = 0;
    int         trig_count = 0;
    int         last_trig_cyc = 0;
    bit         have_last = 1'b0;
    int         busy_len = 0;
    bit         busy_hold = 1'b0;
    int         v_cyc = 0;
    int         idle_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name, input int limit);
        total++;
        bad++;
        $display("FAIL %s: no response within %0d cycles", name, limit);
    endtask

    // Reference model: an accepted sample becomes one packet with the next SEQ
    task automatic model_sample(input int tau);
        logic [15:0] t;
        logic [7:0]  hi;
        logic [7:0]  lo;
        t  = 16'(tau);
        hi = t[15:8];
        lo = t[7:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq_model);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        exp_q.push_back(seq_model ^ hi ^ lo);
        seq_model = seq_model + 8'd1;
    endtask

    // UART responder: busy rises the cycle after a trigger and lasts busy_len cycles
    initial begin
        int  rem;
        bit  trig;
        rem        = 0;
        tx_busy_in = 1'b0;
        forever begin
            @(negedge clk_in);
            trig = tx_trigger_out;
            @(posedge clk_in);
            #1;
            if (busy_hold) begin
                rem        = 0;
                tx_busy_in = 1'b1;
            end else begin
                if (trig) rem = busy_len;
                if (rem > 0) begin
                    tx_busy_in = 1'b1;
                    rem--;
                end else begin
                    tx_busy_in = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard compare and handshake rules on every trigger
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in && tx_trigger_out) begin
                trig_count++;
                check("trigger_while_busy", int'(tx_busy_in), 0);
                if (have_last) check("trigger_spacing_ge2", int'((cyc - last_trig_cyc) >= 2), 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_trigger: actual=%0h required=none", tx_byte_out);
                end else begin
                    check("tx_byte", int'(tx_byte_out), int'(exp_q.pop_front()));
                end
                last_trig_cyc = cyc;
                have_last     = 1'b1;
            end
        end
    end

    task automatic send_one(input int tau);
        @(posedge clk_in);
        #1;
        valid_in  = 1'b1;
        taumin_in = TW'(tau);
        v_cyc     = cyc;
        model_sample(tau);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    // Back-to-back samples while the packetizer is stalled on a busy UART:
    // the stalled packet holds one sample and the FIFO holds DEPTH more.
    task automatic burst(input int n, input bit ramp);
        int t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            t         = ramp ? (i + 1) : int'($urandom_range(0, (1 << TW) - 1));
            valid_in  = 1'b1;
            taumin_in = TW'(t);
            if (i < DEPTH + 1) model_sample(t);
            else if (drop_model < 255) drop_model++;
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_trigs(input int target, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            #2;
            if (trig_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_trigger", limit);
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_in);
            #2;
            if (!busy_out) begin
                ok       = 1'b1;
                idle_cyc = cyc;
                break;
            end
        end
        if (!ok) timeout_fail("wait_idle", limit);
    endtask

    initial begin
        int base;
        rst_in    = 1'b0;
        valid_in  = 1'b0;
        taumin_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_trigger", int'(tx_trigger_out), 0);
        check("reset_byte", int'(tx_byte_out), 0);
        check("reset_drop", int'(drop_count_out), 0);
        check("reset_busy", int'(busy_out), 0);
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);

        // Single packet, idle UART: known bytes and two-cycle latency
        busy_len = 0;
        base     = trig_count;
        send_one(11'h5A3);
        wait_trigs(base + 1, 20);
        check("first_trigger_latency", last_trig_cyc - v_cyc, 2);
        wait_idle(100);
        check("pkt1_trigger_count", trig_count - base, 5);

        // Slow UART: 40 busy cycles per byte; busy_out drops two cycles after last trigger
        busy_len = 40;
        base     = trig_count;
        send_one(int'($urandom_range(0, 2047)));
        wait_trigs(base + 5, 400);
        wait_idle(20);
        check("busy_out_fall_after_last", idle_cyc - last_trig_cyc, 2);
        repeat (60) @(posedge clk_in);
        check("slow_uart_trigger_count", trig_count - base, 5);

        // Random samples paced so the FIFO never overflows, random UART speed
        for (int k = 0; k < 20; k++) begin
            busy_len = int'($urandom_range(0, 5));
            send_one(int'($urandom_range(0, 2047)));
            repeat ($urandom_range(35, 45)) @(posedge clk_in);
        end
        wait_idle(200);

        // Random bursts into a stalled packetizer
        for (int k = 0; k < 3; k++) begin
            busy_hold = 1'b1;
            @(posedge clk_in);
            burst(int'($urandom_range(1, 14)), 1'b0);
            check("burst_drop_count", int'(drop_count_out), drop_model);
            busy_hold = 1'b0;
            busy_len  = int'($urandom_range(0, 3));
            wait_idle(2000);
        end

        // Twelve samples, busy held; then a sample arriving on the IDLE pop of a full FIFO
        busy_hold = 1'b1;
        busy_len  = 0;
        @(posedge clk_in);
        burst(12, 1'b1);
        check("overflow12_drop_count", int'(drop_count_out), drop_model);
        base      = trig_count;
        busy_hold = 1'b0;
        wait_trigs(base + 5, 100);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        valid_in  = 1'b1;
        taumin_in = 11'h7FF;
        model_sample(11'h7FF);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        check("full_pop_push_drop_same", int'(drop_count_out), drop_model);
        wait_idle(500);

        // Reset after two bytes of a packet: outputs clear at once, nothing resumes
        busy_len = 3;
        base     = trig_count;
        send_one(int'($urandom_range(0, 2047)));
        wait_trigs(base + 2, 100);
        rst_in = 1'b0;
        #1;
        check("midreset_trigger", int'(tx_trigger_out), 0);
        check("midreset_byte", int'(tx_byte_out), 0);
        check("midreset_drop", int'(drop_count_out), 0);
        check("midreset_busy", int'(busy_out), 0);
        exp_q.delete();
        seq_model  = 8'h00;
        drop_model = 0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        base   = trig_count;
        repeat (30) @(posedge clk_in);
        check("no_trigger_after_reset", trig_count - base, 0);
        send_one(int'($urandom_range(0, 2047)));
        wait_idle(200);

        // Heavy overload: drop counter saturates at 255
        busy_hold = 1'b1;
        @(posedge clk_in);
        burst(DEPTH + 1 + 300, 1'b0);
        check("drop_saturates", int'(drop_count_out), 255);
        busy_hold = 1'b0;
        busy_len  = 1;
        wait_idle(2000);

        // Enough packets to wrap SEQ past 255 back to 00
        for (int k = 0; k < 250; k++) begin
            busy_len = int'($urandom_range(0, 2));
            send_one(int'($urandom_range(0, 2047)));
            repeat ($urandom_range(24, 30)) @(posedge clk_in);
        end
        wait_idle(500);
        repeat (5) @(posedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_drop_count", int'(drop_count_out), drop_model);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
